// File: rtl/aclk_if.sv
// Digit-level bus of the alarm clock core: BCD load digits and controls in, BCD time and Alarm out.
interface aclk_if;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       AL_ON;
    logic       Alarm;
    logic [1:0] H_out1;
    logic [3:0] H_out0;
    logic [3:0] M_out1;
    logic [3:0] M_out0;
    logic [3:0] S_out1;
    logic [3:0] S_out0;

    modport master (
        output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
        input  Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
    );

    modport slave (
        input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
        output Alarm, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0
    );
endinterface

// File: rtl/aclk_core.sv
// 24-hour BCD alarm clock: 10-cycle tick prescaler, HH:MM:SS counter, loadable time and alarm,
// and a sticky Alarm flag raised when the count rolls into the alarm minute.
module aclk_core (
    input  logic  clk,
    input  logic  reset,
    aclk_if.slave bus
);
    logic [1:0] h1, al_h1, n_h1;
    logic [3:0] h0, m1, m0, s1, s0, tick;
    logic [3:0] al_h0, al_m1, al_m0;
    logic [3:0] n_h0, n_m1, n_m0, n_s1, n_s0;
    logic       alarm;
    logic       load_valid, advance, hit, time_load;

    always_comb begin
        load_valid = (bus.H_in0 <= 4'd9) && (bus.M_in1 <= 4'd5) && (bus.M_in0 <= 4'd9) &&
                     ((bus.H_in1 < 2'd2) || ((bus.H_in1 == 2'd2) && (bus.H_in0 <= 4'd3)));
        time_load  = bus.LD_time && load_valid;
        advance    = (tick == 4'd9);
    end

    // Next time value if a second elapses this cycle; carries ripple seconds -> minutes -> hours.
    always_comb begin
        n_h1 = h1;
        n_h0 = h0;
        n_m1 = m1;
        n_m0 = m0;
        n_s1 = s1;
        n_s0 = s0;
        if (advance) begin
            if (s0 != 4'd9) begin
                n_s0 = s0 + 4'd1;
            end else begin
                n_s0 = 4'd0;
                if (s1 != 4'd5) begin
                    n_s1 = s1 + 4'd1;
                end else begin
                    n_s1 = 4'd0;
                    if (m0 != 4'd9) begin
                        n_m0 = m0 + 4'd1;
                    end else begin
                        n_m0 = 4'd0;
                        if (m1 != 4'd5) begin
                            n_m1 = m1 + 4'd1;
                        end else begin
                            n_m1 = 4'd0;
                            if ((h1 == 2'd2) && (h0 == 4'd3)) begin
                                n_h1 = 2'd0;
                                n_h0 = 4'd0;
                            end else if (h0 == 4'd9) begin
                                n_h1 = h1 + 2'd1;
                                n_h0 = 4'd0;
                            end else begin
                                n_h0 = h0 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // The alarm only fires on the counted rollover into HH:MM:00, never on a load.
    always_comb begin
        hit = advance && (n_s1 == 4'd0) && (n_s0 == 4'd0) &&
              ({n_h1, n_h0, n_m1, n_m0} == {al_h1, al_h0, al_m1, al_m0});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h1    <= 2'd0;
            h0    <= 4'd0;
            m1    <= 4'd0;
            m0    <= 4'd0;
            s1    <= 4'd0;
            s0    <= 4'd0;
            tick  <= 4'd0;
            al_h1 <= 2'd0;
            al_h0 <= 4'd0;
            al_m1 <= 4'd0;
            al_m0 <= 4'd0;
            alarm <= 1'b0;
        end else begin
            if (time_load) begin
                h1   <= bus.H_in1;
                h0   <= bus.H_in0;
                m1   <= bus.M_in1;
                m0   <= bus.M_in0;
                s1   <= 4'd0;
                s0   <= 4'd0;
                tick <= 4'd0;
            end else begin
                h1   <= n_h1;
                h0   <= n_h0;
                m1   <= n_m1;
                m0   <= n_m0;
                s1   <= n_s1;
                s0   <= n_s0;
                tick <= advance ? 4'd0 : tick + 4'd1;
            end

            if (bus.LD_alarm && load_valid) begin
                al_h1 <= bus.H_in1;
                al_h0 <= bus.H_in0;
                al_m1 <= bus.M_in1;
                al_m0 <= bus.M_in0;
            end

            if (bus.STOP_al || !bus.AL_ON) begin
                alarm <= 1'b0;
            end else if (!time_load && hit) begin
                alarm <= 1'b1;
            end
        end
    end

    assign bus.H_out1 = h1;
    assign bus.H_out0 = h0;
    assign bus.M_out1 = m1;
    assign bus.M_out0 = m0;
    assign bus.S_out1 = s1;
    assign bus.S_out0 = s0;
    assign bus.Alarm  = alarm;

endmodule

// File: tb/tb_aclk_core.sv
// Randomized and directed bench for aclk_core; a seconds-of-day reference model feeds a
// scoreboard queue that a separate monitor drains once per clock.
module tb_aclk_core;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    aclk_if bus ();

    aclk_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        logic       alarm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    int   model_secs = 0;
    int   model_tick = 0;
    int   model_almin = 0;
    bit   model_alarm = 1'b0;
    bit   al_on_lvl = 1'b0;

    // Drives one cycle of inputs and pushes what the clock must show after the following edge.
    task automatic applyStimulus(input bit rst, input bit ldt, input bit lda, input bit stop,
                                 input logic [1:0] hi1, input logic [3:0] hi0,
                                 input logic [3:0] mi1, input logic [3:0] mi0);
        int   h, m;
        bit   valid, adv;
        exp_t e;
        @(negedge clk);
        reset        = rst;
        bus.LD_time  = ldt;
        bus.LD_alarm = lda;
        bus.STOP_al  = stop;
        bus.AL_ON    = al_on_lvl;
        bus.H_in1    = hi1;
        bus.H_in0    = hi0;
        bus.M_in1    = mi1;
        bus.M_in0    = mi0;

        h     = int'(hi1) * 10 + int'(hi0);
        m     = int'(mi1) * 10 + int'(mi0);
        valid = (hi0 <= 4'd9) && (mi1 <= 4'd5) && (mi0 <= 4'd9) && (h <= 23);
        adv   = 1'b0;
        if (rst) begin
            model_secs  = 0;
            model_tick  = 0;
            model_almin = 0;
            model_alarm = 1'b0;
        end else begin
            if (ldt && valid) begin
                model_secs = h * 3600 + m * 60;
                model_tick = 0;
            end else if (model_tick == 9) begin
                model_secs = (model_secs + 1) % 86400;
                model_tick = 0;
                adv        = 1'b1;
            end else begin
                model_tick = model_tick + 1;
            end
            if (stop || !al_on_lvl)
                model_alarm = 1'b0;
            else if (adv && (model_secs % 60 == 0) && (model_secs / 60 == model_almin))
                model_alarm = 1'b1;
            if (lda && valid)
                model_almin = h * 60 + m;
        end

        e.h1    = 2'(model_secs / 36000);
        e.h0    = 4'((model_secs / 3600) % 10);
        e.m1    = 4'(((model_secs / 60) % 60) / 10);
        e.m0    = 4'((model_secs / 60) % 10);
        e.s1    = 4'((model_secs % 60) / 10);
        e.s0    = 4'(model_secs % 10);
        e.alarm = model_alarm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic loadDigits(input bit ldt, input bit lda, input int h, input int m);
        applyStimulus(1'b0, ldt, lda, 1'b0, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10));
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [21:0] act_t, exp_t_v;
        e       = exp_q.pop_front();
        act_t   = {bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0, bus.S_out1, bus.S_out0};
        exp_t_v = {e.h1, e.h0, e.m1, e.m0, e.s1, e.s0};
        checks++;
        if (act_t !== exp_t_v) begin
            errors++;
            $display("[TB] FAIL time cycle %0d: got %0d%0d:%0d%0d:%0d%0d required %0d%0d:%0d%0d:%0d%0d",
                     cycle_no, bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0, bus.S_out1, bus.S_out0,
                     e.h1, e.h0, e.m1, e.m0, e.s1, e.s0);
        end
        checks++;
        if (bus.Alarm !== e.alarm) begin
            errors++;
            $display("[TB] FAIL alarm cycle %0d: got %b required %b", cycle_no, bus.Alarm, e.alarm);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0)
                checkOutput();
        end
    end

    initial begin
        int r, hh, mm;
        reset        = 1'b1;
        bus.LD_time  = 1'b0;
        bus.LD_alarm = 1'b0;
        bus.STOP_al  = 1'b0;
        bus.AL_ON    = 1'b0;
        bus.H_in1    = 2'd0;
        bus.H_in0    = 4'd0;
        bus.M_in1    = 4'd0;
        bus.M_in0    = 4'd0;

        $display("[TB] reset and free run");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'd2, 4'd3, 4'd4);
        idle(605);

        $display("[TB] midnight rollover");
        loadDigits(1'b1, 1'b0, 23, 59);
        idle(605);

        $display("[TB] alarm 07:30");
        al_on_lvl = 1'b1;
        loadDigits(1'b0, 1'b1, 7, 30);
        loadDigits(1'b1, 1'b0, 7, 29);
        idle(605);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0, 4'd0);
        idle(600);

        $display("[TB] invalid loads");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 4'd4, 4'd0, 4'd0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'd2, 4'd6, 4'd0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd10, 4'd0, 4'd0);
        idle(3);
        loadDigits(1'b1, 1'b0, 7, 29);
        idle(605);

        $display("[TB] load on tick 9 at 10:15:59");
        loadDigits(1'b1, 1'b0, 10, 15);
        idle(599);
        loadDigits(1'b1, 1'b0, 8, 0);
        idle(20);

        $display("[TB] alarm 00:01 disabled, then reset while ringing");
        al_on_lvl = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
        loadDigits(1'b0, 1'b1, 0, 1);
        idle(620);
        al_on_lvl = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
        loadDigits(1'b0, 1'b1, 0, 1);
        idle(605);
        loadDigits(1'b0, 1'b1, 5, 5);
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
        idle(12);

        $display("[TB] random traffic");
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
            end else if (r < 10) begin
                if ($urandom_range(0, 1) == 0)
                    loadDigits(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 23), $urandom_range(0, 59));
                else
                    applyStimulus(1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b0, 2'($urandom_range(0, 3)),
                                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end else if (r < 22) begin
                mm = (model_secs / 60 + 1) % 1440;
                hh = mm / 60;
                loadDigits(1'b0, 1'b1, hh, mm % 60);
            end else if (r < 26) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0, 4'd0);
            end else if (r < 29) begin
                al_on_lvl = ~al_on_lvl;
                idle(1);
            end else begin
                idle(1);
            end
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aclk_core.md
ACLK_CORE -- requirements
Module: aclk_core

Interface
REQ-001 SHALL have port clk, input, 1, 10 Hz system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-003 SHALL have inputs H_in1 (2 bits), H_in0 (4), M_in1 (4) and M_in0 (4): BCD hour and minute digits for loading the time or the alarm.
REQ-004 SHALL have input LD_time, 1 bit: load the time from the H_in/M_in digits.
REQ-005 SHALL have input LD_alarm, 1 bit: load the alarm from the H_in/M_in digits.
REQ-006 SHALL have input STOP_al, 1 bit: clear Alarm.
REQ-007 SHALL have input AL_ON, 1 bit: alarm function enable.
REQ-008 SHALL have output Alarm, 1 bit, registered: alarm ringing.
REQ-009 SHALL have outputs H_out1 (2 bits), H_out0 (4), M_out1 (4), M_out0 (4), S_out1 (4) and S_out0 (4), registered: current time in BCD.

Function
REQ-010 SHALL hold a tick counter 0..9 that increments every cycle and wraps 9->0; the seconds value SHALL advance by 1 on each cycle where tick==9.
REQ-011 SHALL count in BCD:
- S_out 00..59; 59->00 carries to minutes.
- M_out 00..59; 59->00 carries to hours.
- H_out 00..23; 23:59:59->00:00:00.
REQ-012 SHALL never present a non-BCD digit or an out-of-range value on any time output.
REQ-013 A load input is valid iff H_in1*10+H_in0<=23, H_in0<=9, M_in1<=5 and M_in0<=9.
REQ-014 On LD_time=1 with valid input, the next edge SHALL load H/M from the inputs and force S_out=00 and tick=0; the normal count is suppressed that cycle.
REQ-015 On LD_time=1 with invalid input, the time SHALL keep counting normally; the load is ignored.
REQ-016 On LD_alarm=1 with valid input, the next edge SHALL load the alarm H/M registers; with invalid input they SHALL be unchanged.
REQ-017 LD_alarm SHALL NOT affect the time count.
REQ-018 If LD_time and LD_alarm are both 1 in one cycle, both loads SHALL take effect from the same digits.
REQ-019 Alarm SHALL go 1 on the edge where the counter advances into HH:MM:00 equal to the alarm registers while AL_ON=1; Alarm then coincides with the first cycle the outputs show that time.
REQ-020 A LD_time load, even to a time equal to the alarm, SHALL NOT set Alarm.
REQ-021 Once set, Alarm SHALL stay 1 until STOP_al=1 or AL_ON=0 is sampled, and SHALL clear on that edge.
REQ-022 Alarm SHALL NOT re-assert during the remainder of the same minute.
REQ-023 STOP_al=1 or AL_ON=0 SHALL take priority over a set condition in the same cycle, so Alarm stays 0.
REQ-024 Changing the alarm registers while Alarm=1 SHALL NOT clear Alarm.
REQ-025 Priority per edge: reset > LD_time (valid) > normal count.

Reset
REQ-026 When reset=1 is sampled, the next edge SHALL set:
- all time outputs 00:00:00;
- alarm registers 00:00;
- tick=0;
- Alarm=0.
REQ-027 Reset SHALL override every other input in the same cycle, including mid-count, mid-load and Alarm=1.
REQ-028 Outputs SHALL be X-free from the first edge after reset and SHALL hold reset values while reset=1.
REQ-029 The first increment after reset deassertion SHALL occur 10 edges later (S_out0=1).

Verification
REQ-030 Reset, then 10 cycles -> 00:00:01; after 600 cycles -> 00:01:00.
REQ-031 LD_time with 23:59 pulse, then 600 cycles -> 00:00:00 exactly on cycle 600 with no intermediate invalid value.
REQ-032 LD_alarm 07:30, LD_time 07:29, AL_ON=1, then 600 cycles -> Alarm=1 on the same edge time becomes 07:30:00; STOP_al 1 cycle -> Alarm=0 next edge and stays 0 through 07:30:59.
REQ-033 LD_time with 24:00, 12:60 or 0A digits -> time unchanged and keeps counting; LD_alarm with the same digits -> alarm unchanged.
REQ-034 Alarm 00:01, AL_ON=0 across 00:01:00 -> Alarm stays 0; the same run with AL_ON=1 and reset asserted while Alarm=1 -> Alarm=0 and time 00:00:00 next edge.
REQ-035 LD_time asserted on a tick==9 cycle at 10:15:59 with input 08:00 -> 08:00:00 with tick=0, not 10:16:00.
